// File: rtl/line_refill_arbiter_if.sv
// line_refill_arbiter_if
//  Bundles the I-cache, D-cache and main-memory signals around the line refill arbiter.
//  Modports:
//    slave  - the arbiter: takes cache requests and memory responses, drives the
//             per-cache read/done outputs and the memory request.
//    master - the surrounding caches and memory: drive requests and memory
//             responses, observe arbiter outputs.
//  Signals:
//    i_req/i_addr, i_rvalid/i_rdata/i_idx/i_done             I-cache side
//    d_req/d_we/d_addr/d_wdata, d_rvalid/d_rdata/d_idx/d_done D-cache side
//    mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata     main-memory side
interface line_refill_arbiter_if #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_W        = 32
);
    logic                     i_req;
    logic [ADDR_W-1:0]        i_addr;
    logic                     i_rvalid;
    logic [31:0]              i_rdata;
    logic [LINE_ADDR_LEN-1:0] i_idx;
    logic                     i_done;

    logic                     d_req;
    logic                     d_we;
    logic [ADDR_W-1:0]        d_addr;
    logic [31:0]              d_wdata;
    logic                     d_rvalid;
    logic [31:0]              d_rdata;
    logic [LINE_ADDR_LEN-1:0] d_idx;
    logic                     d_done;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [31:0]              mem_wdata;
    logic                     mem_ack;
    logic [31:0]              mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_rvalid, i_rdata, i_idx, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rvalid, d_rdata, d_idx, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_rvalid, i_rdata, i_idx, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rvalid, d_rdata, d_idx, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/line_refill_arbiter.sv
// line_refill_arbiter
//  Shares one word-wide main-memory port between I-cache line refills and D-cache
//  line refills / write-backs. Each grant moves a whole line as a burst of
//  2^LINE_ADDR_LEN word accesses, then pulses the owner's done for one cycle.
//  Ports:
//    clk  - clock, all state updates on posedge
//    rst  - synchronous active-high reset; aborts any burst without a done pulse
//    bus  - line_refill_arbiter_if.slave (cache request/response + memory port)
//  Configuration:
//    ARB_ROUND_ROBIN_EN defined   - ties go to the requester not served last
//                                   (last-owner flag resets to I, so D wins the first tie)
//    ARB_ROUND_ROBIN_EN undefined - fixed priority, D wins every tie
module line_refill_arbiter #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    line_refill_arbiter_if.slave bus
);

    localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int unsigned TAG_W      = ADDR_W - LINE_ADDR_LEN - 2;
    localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = LINE_ADDR_LEN'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0]         line_q, line_d;
    logic                     own_d_q, own_d_d;   // 1: D-cache owns the current burst
    logic                     pick_d_c;           // grant goes to D this cycle
    logic                     busy_c;
    logic                     unused_c;

    // Word-offset bits of the line addresses are never used.
    assign unused_c = ^{bus.i_addr[LINE_ADDR_LEN+1:0], bus.d_addr[LINE_ADDR_LEN+1:0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;   // 1: D was granted last

    // On a tie, alternate away from the last owner.
    assign pick_d_c = bus.d_req && (!bus.i_req || !last_d_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (bus.d_req || bus.i_req)) begin
            last_d_d = pick_d_c;
        end
    end
`else
    // Fixed priority: D beats I; I may wait behind back-to-back D bursts.
    assign pick_d_c = bus.d_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            own_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            own_d_q <= own_d_d;
        end
    end

    // Next-state: grant in IDLE, count words on ack, one DONE cycle per burst.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        own_d_d = own_d_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d_c) begin
                    own_d_d = 1'b1;
                    line_d  = bus.d_addr[ADDR_W-1:LINE_ADDR_LEN+2];
                    cnt_d   = '0;
                    state_d = bus.d_we ? D_WR : D_RD;
                end else if (bus.i_req) begin
                    own_d_d = 1'b0;
                    line_d  = bus.i_addr[ADDR_W-1:LINE_ADDR_LEN+2];
                    cnt_d   = '0;
                    state_d = I_RD;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (bus.mem_ack) begin
                    // Wraps to 0 on the last word.
                    cnt_d = cnt_q + LINE_ADDR_LEN'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_c = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);

    // Memory side: request held for the whole burst, next word follows an ack directly.
    always_comb begin
        bus.mem_req   = busy_c;
        bus.mem_we    = (state_q == D_WR);
        bus.mem_addr  = busy_c ? {line_q, cnt_q, 2'b00} : '0;
        bus.mem_wdata = (state_q == D_WR) ? bus.d_wdata : '0;
    end

    // Cache side: read data forwarded in the ack cycle, done pulses in DONE.
    always_comb begin
        bus.i_rvalid = (state_q == I_RD) && bus.mem_ack;
        bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
        bus.i_idx    = (state_q == I_RD) ? cnt_q : '0;
        bus.i_done   = (state_q == DONE) && !own_d_q;

        bus.d_rvalid = (state_q == D_RD) && bus.mem_ack;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
        bus.d_idx    = ((state_q == D_RD) || (state_q == D_WR)) ? cnt_q : '0;
        bus.d_done   = (state_q == DONE) && own_d_q;
    end

endmodule

// File: tb/tb_line_refill_arbiter.sv
module tb_line_refill_arbiter;
    localparam int unsigned LAL = 3;
    localparam int unsigned AW  = 32;
    localparam int          TMO = 3000;

    typedef struct {
        bit          owner;    // 1 = D
        bit          we;
        logic [31:0] addr;
        logic [2:0]  idx;
        int          gap;      // cycles from previous last ack to mem_req rise; 0 = unchecked
        bit          consec;   // ack expected exactly one cycle after previous ack
    } acc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_refill_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW)) bus ();

    line_refill_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int lat     = 1;
    int ack_total = 0;
    logic [31:0] wbase = 32'h0;

    acc_t exp_q[$];
    bit   done_q[$];

    assign bus.d_wdata = wbase + 32'(bus.d_idx);

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after 'lat' cycles of request, rdata = address; stray acks while idle.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else if (bus.mem_req) begin
                wcnt++;
                if (wcnt >= lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr;
                    wcnt = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                wcnt = 0;
                bus.mem_ack   = cyc[0];
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted memory access and every done pulse.
    initial begin
        acc_t e;
        bit   ok;
        bit   req_prev;
        int   rise_cyc;
        int   prev_ack_cyc;
        logic [2:0]  got_idx;
        logic [31:0] got_data;
        bit   want_owner;
        req_prev = 1'b0;
        rise_cyc = 0;
        prev_ack_cyc = -100;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !req_prev) rise_cyc = cyc;
            req_prev = bus.mem_req;
            if (!rst) begin
                if (bus.mem_req && bus.mem_ack) begin
                    ack_total++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL access: unexpected access addr=%h we=%0b, want none", bus.mem_addr, bus.mem_we);
                    end else begin
                        e = exp_q.pop_front();
                        vectors++;
                        got_idx  = e.owner ? bus.d_idx : bus.i_idx;
                        if (e.we) got_data = bus.mem_wdata;
                        else      got_data = e.owner ? bus.d_rdata : bus.i_rdata;
                        ok = (bus.mem_we == e.we) && (bus.mem_addr == e.addr) && (got_idx == e.idx)
                           && (bus.i_rvalid == (!e.we && !e.owner)) && (bus.d_rvalid == (!e.we && e.owner))
                           && (got_data == (e.we ? wbase + 32'(e.idx) : e.addr));
                        if (!ok) begin
                            errors++;
                            $display("FAIL access: got we=%0b addr=%h idx=%0d irv=%0b drv=%0b data=%h, want owner=%0b we=%0b addr=%h idx=%0d data=%h",
                                     bus.mem_we, bus.mem_addr, got_idx, bus.i_rvalid, bus.d_rvalid, got_data,
                                     e.owner, e.we, e.addr, e.idx, e.we ? wbase + 32'(e.idx) : e.addr);
                        end
                        if (e.gap != 0) begin
                            vectors++;
                            if (rise_cyc - prev_ack_cyc != e.gap) begin
                                errors++;
                                $display("FAIL grant_gap: got %0d cycles, want %0d", rise_cyc - prev_ack_cyc, e.gap);
                            end
                        end
                        if (e.consec) begin
                            vectors++;
                            if (cyc - prev_ack_cyc != 1) begin
                                errors++;
                                $display("FAIL back_to_back: got %0d cycles between acks, want 1", cyc - prev_ack_cyc);
                            end
                        end
                    end
                    prev_ack_cyc = cyc;
                end else if (bus.i_rvalid || bus.d_rvalid) begin
                    errors++;
                    $display("FAIL rvalid_quiet: got irv=%0b drv=%0b, want 0 0", bus.i_rvalid, bus.d_rvalid);
                end
                if (bus.i_done || bus.d_done) begin
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done: got i_done=%0b d_done=%0b, want no done", bus.i_done, bus.d_done);
                    end else begin
                        want_owner = done_q.pop_front();
                        vectors++;
                        if (bus.i_done == bus.d_done || bus.d_done != want_owner) begin
                            errors++;
                            $display("FAIL done: got i_done=%0b d_done=%0b, want owner d=%0b",
                                     bus.i_done, bus.d_done, want_owner);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_burst(bit owner, bit we, logic [31:0] base, int n, int gap, bit consec);
        acc_t e;
        for (int i = 0; i < n; i++) begin
            e.owner  = owner;
            e.we     = we;
            e.addr   = base + 32'(i * 4);
            e.idx    = 3'(i);
            e.gap    = (i == 0) ? gap : 0;
            e.consec = consec && (i != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(bit owner);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(owner ? bus.d_done : bus.i_done) && n < TMO);
        if (n >= TMO) begin
            errors++;
            $display("FAIL timeout: no done for owner d=%0b, want done", owner);
        end
    endtask

    task automatic wait_acks(int target);
        int n;
        n = 0;
        while (ack_total < target && n < TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= TMO) begin
            errors++;
            $display("FAIL timeout: got %0d acks, want %0d", ack_total, target);
        end
    endtask

    initial begin
        int start;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req",  32'(bus.mem_req), 32'h0);
        check("rst_mem_we",   32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_done",     32'({bus.i_done, bus.d_done}), 32'h0);
        check("rst_idx",      32'({bus.i_idx, bus.d_idx}), 32'h0);
        step();
        rst = 1'b0;
        repeat (2) step();

        // D write-back, 1-cycle ack; d_we/d_addr changes after grant must be ignored.
        lat = 1; wbase = 32'hA000_0000;
        push_burst(1'b1, 1'b1, 32'h0000_0240, 8, 0, 1'b1);
        done_q.push_back(1'b1);
        bus.d_we = 1'b1; bus.d_addr = 32'h0000_0240; bus.d_req = 1'b1;
        start = ack_total;
        wait_acks(start + 1);
        bus.d_we = 1'b0; bus.d_addr = 32'h0000_FFE0;
        wait_done(1'b1);
        bus.d_req = 1'b0;
        repeat (3) step();

        // I-only refill, ack every 3 cycles, offset bits of i_addr ignored.
        lat = 3;
        push_burst(1'b0, 1'b0, 32'h0000_0100, 8, 0, 1'b0);
        done_q.push_back(1'b0);
        bus.i_addr = 32'h0000_0104; bus.i_req = 1'b1;
        wait_done(1'b0);
        bus.i_req = 1'b0;
        repeat (3) step();

        // First tie: D first in both modes, I granted right after D's DONE.
        lat = 2;
        push_burst(1'b1, 1'b0, 32'h0000_0300, 8, 0, 1'b0);
        done_q.push_back(1'b1);
        push_burst(1'b0, 1'b0, 32'h0000_0140, 8, 3, 1'b0);
        done_q.push_back(1'b0);
        bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300; bus.i_addr = 32'h0000_0140;
        bus.d_req = 1'b1; bus.i_req = 1'b1;
        fork
            begin wait_done(1'b1); bus.d_req = 1'b0; end
            begin wait_done(1'b0); bus.i_req = 1'b0; end
        join
        repeat (3) step();

        // D-only write-back, so D is the last owner before the second tie.
        lat = 1; wbase = 32'hB000_0000;
        push_burst(1'b1, 1'b1, 32'h0000_05C0, 8, 0, 1'b1);
        done_q.push_back(1'b1);
        bus.d_we = 1'b1; bus.d_addr = 32'h0000_05C0; bus.d_req = 1'b1;
        wait_done(1'b1);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        repeat (3) step();

        // Second tie.
`ifdef ARB_ROUND_ROBIN_EN
        push_burst(1'b0, 1'b0, 32'h0000_01C0, 8, 0, 1'b1);
        done_q.push_back(1'b0);
        push_burst(1'b1, 1'b0, 32'h0000_06E0, 8, 3, 1'b1);
        done_q.push_back(1'b1);
`else
        push_burst(1'b1, 1'b0, 32'h0000_06E0, 8, 0, 1'b1);
        done_q.push_back(1'b1);
        push_burst(1'b0, 1'b0, 32'h0000_01C0, 8, 3, 1'b1);
        done_q.push_back(1'b0);
`endif
        bus.d_addr = 32'h0000_06E0; bus.i_addr = 32'h0000_01C0;
        bus.d_req = 1'b1; bus.i_req = 1'b1;
        fork
            begin wait_done(1'b1); bus.d_req = 1'b0; end
            begin wait_done(1'b0); bus.i_req = 1'b0; end
        join
        repeat (3) step();

        // Starvation: idle reset returns last owner to I; D requests three bursts, I one.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        push_burst(1'b1, 1'b0, 32'h0000_0A00, 8, 0, 1'b1); done_q.push_back(1'b1);
        push_burst(1'b0, 1'b0, 32'h0000_0800, 8, 3, 1'b1); done_q.push_back(1'b0);
        push_burst(1'b1, 1'b0, 32'h0000_0A00, 8, 3, 1'b1); done_q.push_back(1'b1);
        push_burst(1'b1, 1'b0, 32'h0000_0A00, 8, 3, 1'b1); done_q.push_back(1'b1);
`else
        push_burst(1'b1, 1'b0, 32'h0000_0A00, 8, 0, 1'b1); done_q.push_back(1'b1);
        push_burst(1'b1, 1'b0, 32'h0000_0A00, 8, 3, 1'b1); done_q.push_back(1'b1);
        push_burst(1'b1, 1'b0, 32'h0000_0A00, 8, 3, 1'b1); done_q.push_back(1'b1);
        push_burst(1'b0, 1'b0, 32'h0000_0800, 8, 3, 1'b1); done_q.push_back(1'b0);
`endif
        bus.d_addr = 32'h0000_0A00; bus.i_addr = 32'h0000_0800;
        bus.d_req = 1'b1; bus.i_req = 1'b1;
        fork
            begin wait_done(1'b0); bus.i_req = 1'b0; end
            begin repeat (3) wait_done(1'b1); bus.d_req = 1'b0; end
        join
        repeat (3) step();

        // Reset after the 4th ack: burst aborted, no done, then a clean restart at idx 0.
        lat = 3;
        push_burst(1'b1, 1'b0, 32'h0000_0C00, 4, 0, 1'b0);
        bus.d_addr = 32'h0000_0C00; bus.d_req = 1'b1;
        start = ack_total;
        wait_acks(start + 4);
        step();
        rst = 1'b1; bus.d_req = 1'b0;
        step();
        rst = 1'b0;
        check("abort_mem_req", 32'(bus.mem_req), 32'h0);
        check("abort_done",    32'({bus.i_done, bus.d_done}), 32'h0);
        check("abort_left",    32'(exp_q.size()), 32'h0);
        step();
        push_burst(1'b1, 1'b0, 32'h0000_0C00, 8, 0, 1'b0);
        done_q.push_back(1'b1);
        bus.d_req = 1'b1;
        wait_done(1'b1);
        bus.d_req = 1'b0;
        repeat (3) step();

        // D drops its request after word 2; I raised meanwhile must wait for DONE.
        lat = 1;
        push_burst(1'b1, 1'b0, 32'h0000_0E40, 8, 0, 1'b1);
        done_q.push_back(1'b1);
        push_burst(1'b0, 1'b0, 32'h0000_02A0, 8, 3, 1'b1);
        done_q.push_back(1'b0);
        bus.d_addr = 32'h0000_0E40; bus.d_req = 1'b1;
        start = ack_total;
        wait_acks(start + 2);
        bus.d_req = 1'b0;
        bus.i_addr = 32'h0000_02A0; bus.i_req = 1'b1;
        wait_done(1'b1);
        wait_done(1'b0);
        bus.i_req = 1'b0;
        repeat (5) step();

        check("exp_q_empty",  32'(exp_q.size()), 32'h0);
        check("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
